uart_tx_phy: RTL and testbench

Physical UART transmitter that consumes the SoC's one-cycle uart_tx_valid/uart_tx_data byte pulses and serialises them onto a single TX line as 8N1 frames. The producer has no backpressure, so the block buffers bytes in an internal FIFO and reports dropped bytes through a sticky overflow flag. It sits between minisoc top-level UART outputs and the board pin or the testbench UART monitor.

---
 rtl/uart_tx_phy.sv | 157 +++++++++++++++
 tb/tb_uart_tx_phy.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_phy.sv
// 8N1 UART transmitter with a byte FIFO in front of it.
// Bytes arriving with no free slot are dropped and flagged in a sticky overflow bit.
module uart_tx_phy #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [BW-1:0]   baud_cnt_r, baud_nxt_s;
    logic [2:0]      bit_idx_r, bit_nxt_s;
    logic [7:0]      shift_r, shift_nxt_s;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   count_r, count_nxt_s;
    logic            tx_r, tx_nxt_s;
    logic            busy_r, overflow_r;
    logic            baud_last_s, fifo_empty_s, fifo_full_s;
    logic            pop_s, push_s, drop_s;

    assign baud_last_s  = (baud_cnt_r == BAUD_LAST);
    assign fifo_empty_s = (count_r == LW'(0));
    assign fifo_full_s  = (count_r == LEVEL_FULL);
    // Pop from IDLE, or on the final stop cycle so frames run back-to-back.
    assign pop_s  = !fifo_empty_s && ((state_r == IDLE) || ((state_r == STOP) && baud_last_s));
    assign push_s = in_valid && (!fifo_full_s || pop_s);
    assign drop_s = in_valid && fifo_full_s && !pop_s;

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_level = count_r;
    assign overflow   = overflow_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (pop_s) state_nxt_s = START; else state_nxt_s = IDLE;
            START:   if (baud_last_s) state_nxt_s = DATA; else state_nxt_s = START;
            DATA:    if (baud_last_s && (bit_idx_r == 3'd7)) state_nxt_s = STOP; else state_nxt_s = DATA;
            STOP: begin
                if (baud_last_s) begin
                    if (pop_s) state_nxt_s = START; else state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values; tx is derived from the next state so it is registered
    always_comb begin
        baud_nxt_s  = baud_cnt_r;
        bit_nxt_s   = bit_idx_r;
        shift_nxt_s = shift_r;
        tx_nxt_s    = 1'b1;
        if ((state_r == IDLE) || baud_last_s) begin
            baud_nxt_s = {BW{1'b0}};
        end else begin
            baud_nxt_s = baud_cnt_r + BW'(1);
        end
        if (state_r == START) begin
            bit_nxt_s = 3'd0;
        end else if ((state_r == DATA) && baud_last_s) begin
            bit_nxt_s = bit_idx_r + 3'd1;
        end else begin
            bit_nxt_s = bit_idx_r;
        end
        if (pop_s) begin
            shift_nxt_s = mem_r[rd_ptr_r];
        end else if ((state_r == DATA) && baud_last_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
        end else begin
            shift_nxt_s = shift_r;
        end
        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + LW'(1);
            2'b01:   count_nxt_s = count_r - LW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Registered outputs, counters, pointers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {LW{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_idx_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            count_r    <= count_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= (state_nxt_s != IDLE) || (count_nxt_s != LW'(0));
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= in_data;
    end
endmodule

// File: tb/tb_uart_tx_phy.sv
// Directed bench for uart_tx_phy at 4 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_phy;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clr_overflow = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_level;
    int         total = 0;
    int         bad = 0;
    logic       line_moved;

    uart_tx_phy #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .tx(tx), .busy(busy), .fifo_level(fifo_level), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks frame samples k_from..k_to (one per negedge); sample 0 is the first start-bit cycle.
    task automatic expect_frame(input logic [7:0] d, input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            int   b;
            logic e;
            b = k / CPB;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = d[b-1];
            check($sformatf("tx_%02h_s%0d", d, k), {31'd0, tx}, {31'd0, e});
            check($sformatf("busy_%02h_s%0d", d, k), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #12;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk); in_valid = 1'b0;
        check("t1_level", {29'd0, fifo_level}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_tx_pre", {31'd0, tx}, 32'd1);
        @(negedge clk);
        expect_frame(8'h55, 0, 39);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_tx_end", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);

        // Three back-to-back bytes
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk); in_data = 8'h00;
        check("t2_level_a", {29'd0, fifo_level}, 32'd1);
        @(negedge clk); in_data = 8'hFF;
        check("t2_level_b", {29'd0, fifo_level}, 32'd1);
        expect_frame(8'hA5, 0, 0);
        in_valid = 1'b0;
        check("t2_level_peak", {29'd0, fifo_level}, 32'd2);
        expect_frame(8'hA5, 1, 39);
        expect_frame(8'h00, 0, 39);
        expect_frame(8'hFF, 0, 39);
        check("t2_busy_end", {31'd0, busy}, 32'd0);
        check("t2_level_end", {29'd0, fifo_level}, 32'd0);
        repeat (3) @(negedge clk);

        // Overflow on six strobes into a 4-deep FIFO, then clear and set-wins
        in_valid = 1'b1; in_data = 8'h10;
        @(negedge clk); in_data = 8'h11;
        @(negedge clk); in_data = 8'h12;
        @(negedge clk); in_data = 8'h13;
        @(negedge clk); in_data = 8'h14;
        @(negedge clk); in_data = 8'h15;
        check("t3_level_5", {29'd0, fifo_level}, 32'd4);
        check("t3_ovf_5", {31'd0, overflow}, 32'd0);
        @(negedge clk); in_valid = 1'b0;
        check("t3_level_6", {29'd0, fifo_level}, 32'd4);
        check("t3_ovf_6", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        expect_frame(8'h10, 4, 4);
        clr_overflow = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        in_valid = 1'b1; in_data = 8'h99; clr_overflow = 1'b1;
        expect_frame(8'h10, 5, 5);
        in_valid = 1'b0; clr_overflow = 1'b0;
        check("t4_ovf_setwins", {31'd0, overflow}, 32'd1);
        check("t4_level_full", {29'd0, fifo_level}, 32'd4);
        clr_overflow = 1'b1;
        expect_frame(8'h10, 6, 6);
        clr_overflow = 1'b0;
        check("t4_ovf_clr2", {31'd0, overflow}, 32'd0);
        expect_frame(8'h10, 7, 38);
        // Full FIFO write on the last stop cycle, when the pop frees a slot
        in_valid = 1'b1; in_data = 8'h16;
        expect_frame(8'h10, 39, 39);
        in_valid = 1'b0;
        check("t5_level", {29'd0, fifo_level}, 32'd4);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        expect_frame(8'h11, 0, 39);
        expect_frame(8'h12, 0, 39);
        expect_frame(8'h13, 0, 39);
        expect_frame(8'h14, 0, 39);
        expect_frame(8'h16, 0, 39);
        check("t5_busy_end", {31'd0, busy}, 32'd0);
        check("t5_level_end", {29'd0, fifo_level}, 32'd0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a data bit with two bytes queued
        in_valid = 1'b1; in_data = 8'hC3;
        @(negedge clk); in_data = 8'h01;
        @(negedge clk); in_data = 8'h02;
        expect_frame(8'hC3, 0, 0);
        in_valid = 1'b0;
        check("t6_level_q", {29'd0, fifo_level}, 32'd2);
        expect_frame(8'hC3, 1, 14);
        check("t6_tx_before", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_tx_rst", {31'd0, tx}, 32'd1);
        check("t6_level_rst", {29'd0, fifo_level}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        line_moved = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if ((tx !== 1'b1) || (busy !== 1'b0)) line_moved = 1'b1;
        end
        check("t6_quiet_after", {31'd0, line_moved}, 32'd0);
        check("t6_level_after", {29'd0, fifo_level}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
